// File: rtl/apple1_uart_pia.sv
// apple1_uart_pia: four-register UART window on the Apple 1 6502 bus with RX/TX FIFOs and TX pacing.
// Optional macro UART_UPCASE_EN folds received lowercase ASCII to uppercase when it enters the RX FIFO.
module apple1_uart_pia #(
    parameter logic [15:0] BASE_ADDR  = 16'hD010,
    parameter int          RX_DEPTH   = 16,
    parameter int          TX_DEPTH   = 16,
    parameter int          CTS_MARGIN = 2
) (
    input  logic        clk,
    input  logic        res,
    input  logic        phi_en,
    input  logic [15:0] ab,
    input  logic        rw,
    input  logic [7:0]  dbo,
    output logic [7:0]  dbi,
    output logic        sel,
    output logic [7:0]  tx_byte,
    output logic        tx_stb,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic        uart_cts,
    output logic        rx_overrun
);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam logic [RXW:0] RX_FULL_CNT = (RXW+1)'(RX_DEPTH);
    localparam logic [TXW:0] TX_FULL_CNT = (TXW+1)'(TX_DEPTH);

    typedef enum logic [1:0] {IDLE, STROBE, GAP, WAIT} txState_e;

    logic [15:0] offset;
    logic [1:0]  regSel;
    logic        inWin, rdAcc, wrAcc;

    logic [7:0]     rxMem [RX_DEPTH];
    logic [RXW-1:0] rxRdPtr_q, rxWrPtr_q;
    logic [RXW:0]   rxCount_q, rxCount_d;
    logic           rxEmpty, rxFull, rxPop, rxPush, rxFlush, ovrSet, ovrClr;
    logic [7:0]     rxIn, rxHead;
    logic [5:0]     rxCountSat;

    logic [7:0]     txMem [TX_DEPTH];
    logic [TXW-1:0] txRdPtr_q, txWrPtr_q;
    logic [TXW:0]   txCount_q, txCount_d;
    logic           txEmpty, txFull, txPush, txPop, txFlush;

    txState_e   state_q;
    logic [7:0] dbi_q, txByte_q;
    logic       sel_q, txStb_q, cts_q, ovr_q;
    logic       unusedBits;

    // Subtracting the base makes the window test a single compare, even near address wrap.
    assign offset = ab - BASE_ADDR;
    assign inWin  = (offset < 16'd4);
    assign regSel = offset[1:0];
    assign rdAcc  = phi_en && inWin && rw;
    assign wrAcc  = phi_en && inWin && !rw;

    assign rxEmpty    = (rxCount_q == '0);
    assign rxFull     = (rxCount_q == RX_FULL_CNT);
    assign rxHead     = rxMem[rxRdPtr_q];
    assign rxFlush    = wrAcc && (regSel == 2'd3) && dbo[1];
    assign rxPop      = rdAcc && (regSel == 2'd0) && !rxEmpty;
    assign rxPush     = rx_stb && (!rxFull || rxPop) && !rxFlush;
    assign ovrSet     = rx_stb && rxFull && !rxPop;
    assign ovrClr     = wrAcc && (regSel == 2'd3) && dbo[0];
    assign rxCountSat = (32'(rxCount_q) > 32'd63) ? 6'd63 : 6'(rxCount_q);

`ifdef UART_UPCASE_EN
    assign rxIn = (rx_data[6:0] >= 7'h61 && rx_data[6:0] <= 7'h7A) ? (rx_data & 8'hDF) : rx_data;
`else
    assign rxIn = rx_data;
`endif

    assign txEmpty = (txCount_q == '0);
    assign txFull  = (txCount_q == TX_FULL_CNT);
    assign txFlush = wrAcc && (regSel == 2'd3) && dbo[2];
    assign txPush  = wrAcc && (regSel == 2'd2) && !txFull && !txFlush;
    assign txPop   = (state_q == IDLE) && !txEmpty && !tx_busy;

    assign unusedBits = &{1'b0, dbo[7], rxHead[7]};

    always_comb begin
        rxCount_d = rxCount_q;
        txCount_d = txCount_q;
        if (rxFlush)
            rxCount_d = '0;
        else if (rxPush && !rxPop)
            rxCount_d = rxCount_q + 1'b1;
        else if (rxPop && !rxPush)
            rxCount_d = rxCount_q - 1'b1;
        if (txFlush)
            txCount_d = '0;
        else if (txPush && !txPop)
            txCount_d = txCount_q + 1'b1;
        else if (txPop && !txPush)
            txCount_d = txCount_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rxPush)
            rxMem[rxWrPtr_q] <= rxIn;
        if (txPush)
            txMem[txWrPtr_q] <= {1'b0, dbo[6:0]};
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rxRdPtr_q <= '0;
            rxWrPtr_q <= '0;
            rxCount_q <= '0;
            txRdPtr_q <= '0;
            txWrPtr_q <= '0;
            txCount_q <= '0;
            ovr_q     <= 1'b0;
            cts_q     <= 1'b0;
        end else begin
            rxCount_q <= rxCount_d;
            txCount_q <= txCount_d;
            if (rxFlush) begin
                rxRdPtr_q <= '0;
                rxWrPtr_q <= '0;
            end else begin
                if (rxPop)
                    rxRdPtr_q <= rxRdPtr_q + 1'b1;
                if (rxPush)
                    rxWrPtr_q <= rxWrPtr_q + 1'b1;
            end
            if (txFlush) begin
                txRdPtr_q <= '0;
                txWrPtr_q <= '0;
            end else begin
                if (txPop)
                    txRdPtr_q <= txRdPtr_q + 1'b1;
                if (txPush)
                    txWrPtr_q <= txWrPtr_q + 1'b1;
            end
            if (ovrSet)
                ovr_q <= 1'b1;
            else if (ovrClr)
                ovr_q <= 1'b0;
            // CTS follows the post-edge count so it moves on the same edge as the push.
            cts_q <= ((RX_DEPTH - int'(rxCount_d)) <= CTS_MARGIN);
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sel_q <= 1'b0;
            dbi_q <= 8'h00;
        end else if (phi_en) begin
            sel_q <= inWin;
            if (rdAcc) begin
                case (regSel)
                    2'd0:    dbi_q <= rxEmpty ? 8'h00 : {1'b1, rxHead[6:0]};
                    2'd1:    dbi_q <= {~rxEmpty, 7'b0};
                    2'd2:    dbi_q <= {txFull, 7'b0};
                    default: dbi_q <= {ovr_q, txFull, rxCountSat};
                endcase
            end
        end
    end

    // The GAP state gives the transmitter a cycle to raise busy before WAIT samples it.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            txByte_q <= 8'h00;
            txStb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (txPop) begin
                        txByte_q <= txMem[txRdPtr_q];
                        txStb_q  <= 1'b1;
                        state_q  <= STROBE;
                    end
                end
                STROBE: begin
                    txStb_q <= 1'b0;
                    state_q <= GAP;
                end
                GAP:  state_q <= WAIT;
                WAIT: begin
                    if (!tx_busy)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbi        = dbi_q;
    assign sel        = sel_q;
    assign tx_byte    = txByte_q;
    assign tx_stb     = txStb_q;
    assign uart_cts   = cts_q;
    assign rx_overrun = ovr_q;
endmodule

// File: tb/tb_apple1_uart_pia.sv
// tb_apple1_uart_pia: directed and randomized self-checking bench for apple1_uart_pia.
// A queue-based reference model predicts every bus read, status flag and transmitted byte.
module tb_apple1_uart_pia;
    localparam logic [15:0] BASE = 16'hD010;
    localparam int RXD = 16;
    localparam int CTS = 2;

    logic clk = 1'b0;
    logic res, phi_en, rw, sel, tx_stb, tx_busy, rx_stb, uart_cts, rx_overrun;
    logic [15:0] ab;
    logic [7:0] dbo, dbi, tx_byte, rx_data;

    int nAsserts = 0;
    int nFail = 0;

    // Reference model state
    logic [7:0] rxQ[$];
    logic [7:0] txExp[$];
    logic mOvr;
    logic expTxFull;
    logic [7:0] lastDbi;

    // Transmitter model and strobe monitor state
    logic [7:0] stbBytes[$];
    logic stbBusy[$];
    int stbCyc[$];
    int stbLong = 0;
    logic prevStb = 1'b0;
    int cyc = 0;
    int busyCnt;
    logic busyHold;

    apple1_uart_pia #(.BASE_ADDR(BASE), .RX_DEPTH(RXD), .TX_DEPTH(16), .CTS_MARGIN(CTS)) dut (
        .clk(clk), .res(res), .phi_en(phi_en), .ab(ab), .rw(rw), .dbo(dbo), .dbi(dbi), .sel(sel),
        .tx_byte(tx_byte), .tx_stb(tx_stb), .tx_busy(tx_busy), .rx_data(rx_data), .rx_stb(rx_stb),
        .uart_cts(uart_cts), .rx_overrun(rx_overrun)
    );

    always #10 clk = ~clk;

    // Counts clock edges so strobe spacing can be measured
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stays busy for 10 cycles after each strobe it sees
    always @(posedge clk or negedge res) begin
        if (!res)
            busyCnt <= 0;
        else if (tx_stb)
            busyCnt <= 10;
        else if (busyCnt != 0)
            busyCnt <= busyCnt - 1;
    end
    assign tx_busy = busyHold || (busyCnt != 0);

    // Records every strobe, the busy level it started under, and strobes lasting over one cycle
    always @(negedge clk) begin
        if (tx_stb) begin
            stbBytes.push_back(tx_byte);
            stbBusy.push_back(tx_busy);
            stbCyc.push_back(cyc);
            if (prevStb) stbLong <= stbLong + 1;
        end
        prevStb <= tx_stb;
    end

    // Global time bound so a stuck design still terminates
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: observed no completion, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] fold(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef UART_UPCASE_EN
        if (b[6:0] >= 7'h61 && b[6:0] <= 7'h7A) r[5] = 1'b0;
`endif
        return r;
    endfunction

    function automatic void modelPush(input logic [7:0] d);
        if (rxQ.size() < RXD) rxQ.push_back(fold(d));
        else mOvr = 1'b1;
    endfunction

    function automatic logic [7:0] modelRead(input int r);
        logic [7:0] e;
        int n;
        n = rxQ.size();
        case (r)
            0: begin
                if (n > 0) begin
                    e = {1'b1, rxQ[0][6:0]};
                    void'(rxQ.pop_front());
                end else e = 8'h00;
            end
            1: e = {n != 0, 7'b0};
            2: e = {expTxFull, 7'b0};
            default: e = {mOvr, expTxFull, (n > 63) ? 6'd63 : 6'(n)};
        endcase
        return e;
    endfunction

    // Counts and checks one comparison
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock of bus and receiver activity, driven at negedge and sampled just after posedge
    task automatic applyStimulus(input logic busEn, input logic [15:0] addr, input logic rwIn,
                                 input logic [7:0] wdata, input logic pushEn, input logic [7:0] pushData,
                                 output logic [7:0] rdata);
        @(negedge clk);
        phi_en = busEn; ab = addr; rw = rwIn; dbo = wdata; rx_stb = pushEn; rx_data = pushData;
        @(posedge clk);
        #1;
        rdata = dbi;
        phi_en = 1'b0; rx_stb = 1'b0; rw = 1'b1;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [7:0] d);
        applyStimulus(1'b1, addr, 1'b1, 8'h00, 1'b0, 8'h00, d);
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [7:0] d);
        logic [7:0] unusedRd;
        applyStimulus(1'b1, addr, 1'b0, d, 1'b0, 8'h00, unusedRd);
    endtask

    task automatic rxPush(input logic [7:0] d);
        logic [7:0] unusedRd;
        applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, d, unusedRd);
        modelPush(d);
    endtask

    task automatic doRead(input int r, input string tag);
        logic [7:0] got, e;
        busRead(BASE + 16'(r), got);
        e = modelRead(r);
        lastDbi = e;
        checkOutput(tag, got, e);
    endtask

    task automatic doWrite3(input logic [7:0] v);
        busWrite(BASE + 16'd3, v);
        if (v[1]) rxQ.delete();
        if (v[0]) mOvr = 1'b0;
    endtask

    task automatic txWrite(input logic [7:0] d);
        busWrite(BASE + 16'd2, d);
        txExp.push_back({1'b0, d[6:0]});
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_ovr"}, 8'(rx_overrun), 8'(mOvr));
        checkOutput({tag, "_cts"}, 8'(uart_cts), 8'((RXD - rxQ.size()) <= CTS));
    endtask

    task automatic checkTx(input string tag, input int base);
        for (int i = 0; i < 3000 && stbBytes.size() < base + txExp.size(); i++) @(negedge clk);
        repeat (30) @(negedge clk);
        checkOutput({tag, "_count"}, 8'(stbBytes.size() - base), 8'(txExp.size()));
        for (int i = 0; i < txExp.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (base + i < stbBytes.size()) ? stbBytes[base + i] : 8'hxx, txExp[i]);
    endtask

    initial begin
        logic [7:0] got, b, e;
        int base, longBase, op, txWrites;
        logic found;

        res = 1'b0; phi_en = 1'b0; ab = 16'h0000; rw = 1'b1; dbo = 8'h00;
        rx_data = 8'h00; rx_stb = 1'b0; busyHold = 1'b0; mOvr = 1'b0; expTxFull = 1'b0; lastDbi = 8'h00;

        // Reset held with receiver strobes arriving
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx_stb = i[0]; rx_data = 8'h55;
        end
        #1;
        checkOutput("rst_dbi", dbi, 8'h00);
        checkOutput("rst_sel", 8'(sel), 8'h00);
        checkOutput("rst_txstb", 8'(tx_stb), 8'h00);
        checkOutput("rst_txbyte", tx_byte, 8'h00);
        checkOutput("rst_cts", 8'(uart_cts), 8'h00);
        checkOutput("rst_ovr", 8'(rx_overrun), 8'h00);
        @(negedge clk);
        rx_stb = 1'b0; res = 1'b1;
        repeat (2) @(negedge clk);
        doRead(1, "rst_rxctl");
        checkOutput("sel_hit", 8'(sel), 8'h01);

        // Basic receive path and window decode edges
        rxPush(8'h41);
        rxPush(8'h42);
        doRead(0, "rx_first");
        busRead(BASE + 16'd4, got);
        checkOutput("sel_above", 8'(sel), 8'h00);
        checkOutput("dbi_hold_above", got, lastDbi);
        busRead(BASE - 16'd1, got);
        checkOutput("sel_below", 8'(sel), 8'h00);
        checkOutput("dbi_hold_below", got, lastDbi);
        doRead(0, "rx_second");
        doRead(0, "rx_empty");

        // Overflow and overrun clear, then flush
        for (int i = 0; i < RXD + 1; i++) rxPush(8'($urandom));
        checkFlags("ovf");
        doRead(3, "ovf_status");
        doWrite3(8'h01);
        checkFlags("ovf_clr");
        doWrite3(8'h02);
        doRead(1, "flush_rxctl");

        // Flow control threshold
        for (int i = 0; i < 14; i++) begin
            rxPush(8'($urandom));
            checkFlags($sformatf("cts_push%0d", i + 1));
        end
        doRead(0, "cts_pop");
        checkFlags("cts_after_pop");
        doWrite3(8'h02);

        // Pop on a full FIFO in the same edge as a receive
        for (int i = 0; i < RXD; i++) rxPush(8'($urandom));
        b = 8'($urandom);
        applyStimulus(1'b1, BASE, 1'b1, 8'h00, 1'b1, b, got);
        e = modelRead(0);
        modelPush(b);
        checkOutput("full_simul_rd", got, e);
        checkFlags("full_simul");
        doRead(3, "full_simul_status");
        for (int i = 0; i < RXD; i++) doRead(0, $sformatf("full_drain%0d", i));

        // Pop on an empty FIFO in the same edge as a receive
        b = 8'($urandom);
        applyStimulus(1'b1, BASE, 1'b1, 8'h00, 1'b1, b, got);
        e = modelRead(0);
        modelPush(b);
        checkOutput("empty_simul_rd", got, e);
        doRead(3, "empty_simul_status");
        doRead(0, "empty_simul_pop");

        // Case folding boundaries
        rxPush(8'h61); rxPush(8'h7A); rxPush(8'h7B); rxPush(8'h60); rxPush(8'hE1);
        for (int i = 0; i < 5; i++) doRead(0, $sformatf("fold%0d", i));

        // Transmit pacing
        base = stbBytes.size(); longBase = stbLong; txExp.delete();
        txWrite(8'hC8);
        txWrite(8'hE9);
        checkTx("txdrain", base);
        checkOutput("txdrain_48", (stbBytes.size() > base) ? stbBytes[base] : 8'hxx, 8'h48);
        checkOutput("txdrain_69", (stbBytes.size() > base + 1) ? stbBytes[base + 1] : 8'hxx, 8'h69);
        if (stbCyc.size() > base + 1) begin
            checkOutput("txdrain_spacing", 8'((stbCyc[base + 1] - stbCyc[base]) >= 4), 8'h01);
            checkOutput("txdrain_busy_low", 8'(stbBusy[base + 1]), 8'h00);
        end
        checkOutput("txdrain_one_cycle", 8'(stbLong - longBase), 8'h00);

        // TX full with transmitter held busy; the extra byte is dropped
        busyHold = 1'b1;
        base = stbBytes.size(); txExp.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            busWrite(BASE + 16'd2, b);
            if (i < 16) txExp.push_back({1'b0, b[6:0]});
        end
        expTxFull = 1'b1;
        doRead(2, "txfull_txdata");
        doRead(3, "txfull_status");
        busyHold = 1'b0;
        expTxFull = 1'b0;
        checkTx("txfull", base);

        // TX flush discards queued bytes
        busyHold = 1'b1;
        base = stbBytes.size(); txExp.delete();
        for (int i = 0; i < 3; i++) busWrite(BASE + 16'd2, 8'($urandom));
        doWrite3(8'h04);
        doRead(2, "txflush_txdata");
        busyHold = 1'b0;
        checkTx("txflush", base);

        // Randomized mix of bus and receiver traffic against the model
        base = stbBytes.size(); txExp.delete(); txWrites = 0;
        for (int k = 0; k < 150; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: rxPush(8'($urandom));
                3: doRead(0, "rnd_rxdata");
                4: doRead(3, "rnd_status");
                5: doRead($urandom_range(1, 2), "rnd_ctl");
                6: begin
                    if (txWrites < 10) begin
                        txWrite(8'($urandom));
                        txWrites++;
                    end else doRead(0, "rnd_rxdata");
                end
                7: begin
                    if ($urandom_range(0, 1) == 0) busRead(BASE - 16'(1 + $urandom_range(0, 50)), got);
                    else busRead(BASE + 16'(4 + $urandom_range(0, 50)), got);
                    checkOutput("rnd_miss_sel", 8'(sel), 8'h00);
                    checkOutput("rnd_miss_hold", got, lastDbi);
                end
                8: begin
                    b = 8'($urandom);
                    applyStimulus(1'b1, BASE, 1'b1, 8'h00, 1'b1, b, got);
                    e = modelRead(0);
                    modelPush(b);
                    lastDbi = e;
                    checkOutput("rnd_simul", got, e);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) doWrite3(8'h01);
                    else busWrite(BASE + 16'($urandom_range(0, 1)), 8'($urandom));
                end
            endcase
            checkFlags("rnd");
        end
        checkTx("rndtx", base);

        // Reset asserted while a strobe is high
        busWrite(BASE + 16'd2, 8'h5A);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (tx_stb) found = 1'b1;
        end
        checkOutput("midrst_stb_seen", 8'(found), 8'h01);
        #2;
        res = 1'b0;
        #1;
        checkOutput("midrst_txstb", 8'(tx_stb), 8'h00);
        checkOutput("midrst_txbyte", tx_byte, 8'h00);
        checkOutput("midrst_sel", 8'(sel), 8'h00);
        @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
